dict_compressor: RTL

DICT_COMPRESSOR -- requirements
Module: dict_compressor

---
 rtl/dict_compressor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dict_compressor.sv
// Vector-quantising compressor: maps each 4-bit chunk of a 16-bit word to the nearest entry
// of a fixed 8-entry codebook, one chunk per cycle, and keeps a running distortion total.
module dict_compressor #(
  parameter int unsigned CHUNK_SIZE    = 4,
  parameter int unsigned CODEBOOK_SIZE = 8,
  parameter int unsigned INDEX_BITS    = $clog2(CODEBOOK_SIZE),
  parameter int unsigned NUM_CHUNKS    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_CHUNKS*CHUNK_SIZE-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CHUNKS*INDEX_BITS-1:0] out_index,
  output logic [2:0]                       out_dist,
  input  logic                             dist_clear,
  output logic [15:0]                      dist_total
);

  localparam int unsigned CntW = $clog2(NUM_CHUNKS);

  // Entry i lives at bits [4i+3:4i]; must match the decompressor's table.
  localparam logic [CODEBOOK_SIZE*CHUNK_SIZE-1:0] CodeTable = 32'h7C8F_B920;

  typedef enum logic [1:0] {StIdle, StEnc, StHold} state_e;

  state_e                          state_q;
  logic [CntW-1:0]                 cnt_q;
  logic [NUM_CHUNKS*CHUNK_SIZE-1:0] word_q;
  logic [2:0]                      dist_acc_q;

  logic [CHUNK_SIZE-1:0] chunk;
  logic [INDEX_BITS-1:0] best_idx;
  logic [2:0]            best_dist;
  logic [2:0]            cand;
  logic [16:0]           sum_wide;
  logic [15:0]           sum_sat;

  function automatic logic [2:0] ham(input logic [CHUNK_SIZE-1:0] x);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < int'(CHUNK_SIZE); i++) c = c + 3'(x[i]);
    return c;
  endfunction

  assign in_ready = rst_n && (state_q == StIdle);

  always_comb begin
    chunk = '0;
    for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
      if (cnt_q == CntW'(k)) chunk = word_q[k*CHUNK_SIZE +: CHUNK_SIZE];
    end
  end

  // Strict '<' keeps the lowest index on ties.
  always_comb begin
    best_idx  = '0;
    best_dist = 3'd7;
    cand      = '0;
    for (int i = 0; i < int'(CODEBOOK_SIZE); i++) begin
      cand = ham(chunk ^ CodeTable[i*CHUNK_SIZE +: CHUNK_SIZE]);
      if (cand < best_dist) begin
        best_dist = cand;
        best_idx  = INDEX_BITS'(i);
      end
    end
  end

  assign sum_wide = {1'b0, dist_total} + 17'(out_dist);
  assign sum_sat  = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      dist_acc_q <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_dist   <= '0;
      dist_total <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q     <= in_data;
            cnt_q      <= '0;
            dist_acc_q <= '0;
            state_q    <= StEnc;
          end
        end
        StEnc: begin
          for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
            if (cnt_q == CntW'(k)) out_index[k*INDEX_BITS +: INDEX_BITS] <= best_idx;
          end
          dist_acc_q <= dist_acc_q + best_dist;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == CntW'(NUM_CHUNKS - 1)) begin
            out_dist  <= dist_acc_q + best_dist;
            out_valid <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Clear has priority over a coincident handshake.
      if (dist_clear) dist_total <= '0;
      else if (state_q == StHold && out_ready) dist_total <= sum_sat;
    end
  end

endmodule
